// File: rtl/param_shift_engine.sv
// param_shift_engine: parametrised multi-mode shift/rotate register.
// Parallel load, then shifts one bit per clock under a busy/done handshake.
module param_shift_engine #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] in,
    input  logic             start,
    input  logic [2:0]       mode,
    input  logic [CNT_W-1:0] amount,
    input  logic             ser_in,
    output logic [WIDTH-1:0] out,
    output logic             ser_out,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [2:0] M_SRL = 3'd0;
    localparam logic [2:0] M_SLL = 3'd1;
    localparam logic [2:0] M_SRA = 3'd2;
    localparam logic [2:0] M_ROR = 3'd3;
    localparam logic [2:0] M_ROL = 3'd4;

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t           state;
    logic [CNT_W-1:0] count;
    logic [2:0]       mode_q;

    logic [WIDTH-1:0] step_word;
    logic             step_bit;

    // One 1-bit step of the latched operation; reserved modes hold.
    always_comb begin
        step_word = out;
        step_bit  = ser_out;
        unique case (mode_q)
            M_SRL: begin
                step_word = {ser_in, out[WIDTH-1:1]};
                step_bit  = out[0];
            end
            M_SLL: begin
                step_word = {out[WIDTH-2:0], ser_in};
                step_bit  = out[WIDTH-1];
            end
            M_SRA: begin
                step_word = {out[WIDTH-1], out[WIDTH-1:1]};
                step_bit  = out[0];
            end
            M_ROR: begin
                step_word = {out[0], out[WIDTH-1:1]};
                step_bit  = out[0];
            end
            M_ROL: begin
                step_word = {out[WIDTH-2:0], out[WIDTH-1]};
                step_bit  = out[WIDTH-1];
            end
            default: begin
                step_word = out;
                step_bit  = ser_out;
            end
        endcase
    end

    // Control FSM with registered datapath and handshake outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            out     <= '0;
            ser_out <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            count   <= '0;
            mode_q  <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    busy <= 1'b0;
                    done <= 1'b0;
                    if (load) begin
                        out <= in;
                    end else if (start) begin
                        mode_q <= mode;
                        if (amount == '0) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            count <= amount;
                            state <= SHIFT;
                            busy  <= 1'b1;
                        end
                    end
                end
                SHIFT: begin
                    out     <= step_word;
                    ser_out <= step_bit;
                    count   <= count - CNT_ONE;
                    if (count == CNT_ONE) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_param_shift_engine.sv
// tb_param_shift_engine: scoreboard bench for param_shift_engine.
// Driver queues expected results; monitor checks them on each done pulse.
module tb_param_shift_engine;

    localparam int WIDTH  = 8;
    localparam int CNT_W  = 4;
    localparam int PERIOD = 10;
    localparam int HALF   = 5;

    logic             clk;
    logic             reset;
    logic             load;
    logic [WIDTH-1:0] in;
    logic             start;
    logic [2:0]       mode;
    logic [CNT_W-1:0] amount;
    logic             ser_in;
    logic [WIDTH-1:0] out;
    logic             ser_out;
    logic             busy;
    logic             done;

    typedef struct {
        string      name;
        logic [7:0] exp_out;
        logic       exp_ser;
        int         exp_lat;
        longint     t0;
    } exp_t;

    exp_t sb[$];

    int n_cmp = 0;
    int n_bad = 0;

    param_shift_engine #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk     (clk),
        .reset   (reset),
        .load    (load),
        .in      (in),
        .start   (start),
        .mode    (mode),
        .amount  (amount),
        .ser_in  (ser_in),
        .out     (out),
        .ser_out (ser_out),
        .busy    (busy),
        .done    (done)
    );

    initial clk = 1'b0;
    always #HALF clk = ~clk;

    task automatic check(input string name, input longint act,
                         input longint exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: counts busy cycles and checks each done against the queue.
    int  busy_cnt  = 0;
    logic prev_done = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        longint lat;
        if (reset) begin
            busy_cnt  = 0;
            prev_done = 1'b0;
        end else begin
            if (busy) busy_cnt++;
            if (done) begin
                check("done_width", longint'(prev_done), 0);
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_done: got done=1 expected none");
                end else begin
                    e   = sb.pop_front();
                    lat = ($time - e.t0 - HALF) / PERIOD;
                    check({e.name, "_out"}, longint'(out), longint'(e.exp_out));
                    check({e.name, "_ser"}, longint'(ser_out), longint'(e.exp_ser));
                    check({e.name, "_busy"}, longint'(busy_cnt), longint'(e.exp_lat));
                    check({e.name, "_lat"}, lat, longint'(e.exp_lat));
                end
                busy_cnt = 0;
            end
            prev_done = done;
        end
    end

    task automatic do_load(input logic [7:0] v);
        @(negedge clk);
        load = 1'b1;
        in   = v;
        @(posedge clk);
        #1 load = 1'b0;
    endtask

    task automatic issue(input string name, input logic [2:0] m,
                         input int amt, input logic si,
                         input logic [7:0] eo, input logic es);
        exp_t e;
        @(negedge clk);
        start  = 1'b1;
        mode   = m;
        amount = CNT_W'(amt);
        ser_in = si;
        @(posedge clk);
        e.name    = name;
        e.exp_out = eo;
        e.exp_ser = es;
        e.exp_lat = amt;
        e.t0      = $time;
        sb.push_back(e);
        #1 start = 1'b0;
        mode   = 3'd7;
        amount = '1;
    endtask

    task automatic op(input string name, input logic [2:0] m,
                      input int amt, input logic si,
                      input logic [7:0] eo, input logic es);
        issue(name, m, amt, si, eo, es);
        repeat (amt + 2) @(posedge clk);
    endtask

    initial begin
        reset  = 1'b1;
        load   = 1'b1;
        in     = 8'hD2;
        start  = 1'b0;
        mode   = 3'd0;
        amount = '0;
        ser_in = 1'b0;

        // Reset dominates load.
        repeat (3) begin
            @(negedge clk);
            check("rst_out", longint'(out), 0);
            check("rst_busy", longint'(busy), 0);
        end
        check("rst_ser", longint'(ser_out), 0);
        check("rst_done", longint'(done), 0);

        @(negedge clk);
        reset = 1'b0;
        load  = 1'b0;
        do_load(8'hD2);
        @(negedge clk);
        check("load_out", longint'(out), 'hD2);

        op("sra3", 3'd2, 3, 1'b0, 8'hFA, 1'b0);

        do_load(8'h0F);
        op("srl2", 3'd0, 2, 1'b1, 8'hC3, 1'b1);

        do_load(8'h81);
        op("sll1", 3'd1, 1, 1'b0, 8'h02, 1'b1);

        do_load(8'h96);
        op("rol4", 3'd4, 4, 1'b0, 8'h69, 1'b1);
        op("rsv6", 3'd6, 3, 1'b0, 8'h69, 1'b1);
        op("ror8", 3'd3, 8, 1'b0, 8'h69, 1'b0);
        op("amt0", 3'd0, 0, 1'b1, 8'h69, 1'b0);

        // Load and start together: load wins, no operation.
        @(negedge clk);
        load   = 1'b1;
        start  = 1'b1;
        in     = 8'h3C;
        mode   = 3'd0;
        amount = CNT_W'(5);
        @(posedge clk);
        #1 load = 1'b0;
        start = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("ld_st_busy", longint'(busy), 0);
        end
        check("ld_st_out", longint'(out), 'h3C);

        // Load/start mid-shift are ignored.
        do_load(8'h96);
        issue("sll5_dist", 3'd1, 5, 1'b0, 8'hC0, 1'b0);
        @(negedge clk);
        load   = 1'b1;
        in     = 8'hFF;
        start  = 1'b1;
        mode   = 3'd3;
        amount = CNT_W'(1);
        @(negedge clk);
        load  = 1'b0;
        start = 1'b0;
        repeat (6) @(posedge clk);

        // Reset mid-operation aborts with no done pulse.
        do_load(8'hA5);
        @(negedge clk);
        start  = 1'b1;
        mode   = 3'd0;
        amount = CNT_W'(10);
        ser_in = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (4) @(posedge clk);
        #1 reset = 1'b1;
        #1;
        check("abort_out", longint'(out), 0);
        check("abort_busy", longint'(busy), 0);
        check("abort_done", longint'(done), 0);
        @(negedge clk);
        reset = 1'b0;
        repeat (15) @(negedge clk);
        check("abort_idle_busy", longint'(busy), 0);

        check("sb_empty", longint'(sb.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/param_shift_engine.md
Name: param_shift_engine

Overview:
- Parametrised, multi-mode shift register; successor to the fixed 4-bit right shifter.
- Parallel-loads a WIDTH-bit word, then on a start request shifts or rotates it by a programmable count, one bit position per clock.
- Reports progress with a busy/done handshake and exposes a serial output.
- Used as a datapath shifter and serial converter inside the course distribution designs.

Parameters:
- WIDTH, 8, data word width in bits (>= 2).
- CNT_W, 4, width of the shift-amount field; maximum single-operation shift is 2^CNT_W - 1.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- load  input  1  parallel-load request, sampled only in IDLE.
- in  input  WIDTH  parallel load data.
- start  input  1  shift-operation request, sampled only in IDLE.
- mode  input  3  operation select, latched on start.
- amount  input  CNT_W  number of bit positions to shift, latched on start.
- ser_in  input  1  serial fill bit for logical modes, sampled on every shift edge.
- out  output  WIDTH  register contents.
- ser_out  output  1  last bit shifted or rotated out; registered.
- busy  output  1  high while in SHIFT.
- done  output  1  one-cycle completion pulse.

Behaviour:
- Reset (asynchronous, active-high): out=0, ser_out=0, busy=0, done=0, state=IDLE, count=0, latched mode=0. Reset asserted mid-operation aborts immediately; no done pulse follows.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - load=1 -> out<=in on the next edge; stay in IDLE.
  - load=0 and start=1 -> latch mode and amount. If amount=0, go to DONE with out unchanged. Otherwise go to SHIFT with count<=amount.
  - load and start both high -> load wins, start is ignored.
- SHIFT:
  - busy=1. Each edge applies one 1-bit operation to out, updates ser_out and decrements count.
  - The edge on which count goes 1->0 performs the final shift and moves to DONE.
  - load and start are ignored while in SHIFT.
- DONE: done=1 for exactly one cycle, busy=0; next edge returns to IDLE. load and start are ignored in DONE.
- Timing: start sampled at edge 0 -> shifts occur at edges 1..N -> done is high between edges N and N+1. A new start is accepted at edge N+1 at the earliest.
- Modes (per shift step):
  - 0 SRL: out<={ser_in,out[W-1:1]}, ser_out<=out[0].
  - 1 SLL: out<={out[W-2:0],ser_in}, ser_out<=out[W-1].
  - 2 SRA: out<={out[W-1],out[W-1:1]}, ser_out<=out[0].
  - 3 ROR: out<={out[0],out[W-1:1]}, ser_out<=out[0].
  - 4 ROL: out<={out[W-2:0],out[W-1]}, ser_out<=out[W-1].
  - 5-7 reserved: out and ser_out hold; the count and handshake still run for N cycles.
- A rotate by an amount >= WIDTH wraps naturally (e.g. WIDTH rotates returns the original word).
- mode and amount changes after start are ignored until the next accepted start.
- ser_out holds its value outside shift edges.

Test Plan (WIDTH=8, CNT_W=4):
- Reset high, in=0xD2, load=1 -> out=0x00 and busy=0 throughout; release reset, load one cycle -> out=0xD2 after 1 edge.
- out=0xD2, start with mode=2, amount=3 -> busy for 3 cycles, out=0xFA, done pulses one cycle on the 4th cycle after start.
- out=0x0F, mode=0, amount=2, ser_in=1 -> out=0xC3, ser_out=1. Then out=0x81, mode=1, amount=1, ser_in=0 -> out=0x02, ser_out=1.
- out=0x96, mode=4, amount=4 -> out=0x69. Then mode=3, amount=8 -> out=0x69 unchanged, busy for 8 cycles.
- amount=0 start -> done high the cycle after start, busy never high, out unchanged. load and start together in IDLE -> out=in, no busy or done.
- Start mode=0, amount=10; assert reset at cycle 4 -> out=0 immediately, busy=0, no done pulse. load or start pulsed mid-shift (no reset) -> ignored, result matches the undisturbed run.
